pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Arbitrates four hazard sources, in priority order: data-memory wait, taken branch, multi-cycle mult/div busy, load-use.
- Drives the per-stage register write enables and the control-bubble mux select.
- Owns the mult/div occupancy FSM and its latency counter.

Parameters:
- MD_LATENCY, 32, cycles the mult/div unit is busy after a start is accepted (must be ≥2).
- CNT_W, 6, width of the latency counter; must hold MD_LATENCY.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IF_ID_rs  in  5  rs of the instruction in ID.
- IF_ID_rt  in  5  rt of the instruction in ID.
- ID_EX_rt  in  5  destination of the instruction in EX.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_Branch_Taken  in  1  branch/jump resolved taken in EX.
- ID_MD_Start  in  1  instruction in ID is mult/multu/div/divu.
- ID_MD_Use  in  1  instruction in ID is mfhi/mflo.
- EX_MEM_MemAccess  in  1  instruction in MEM accesses data memory.
- MEM_Ready  in  1  data memory has completed the access.
- PC_Write  out  1  PC load enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Write  out  1  ID/EX register enable.
- EX_MEM_Write  out  1  EX/MEM register enable.
- Control_Write  out  1  0 selects zero control into ID/EX (bubble).
- IF_ID_Flush  out  1  clear IF/ID to a nop.
- MEM_WB_Bubble  out  1  write a nop into MEM/WB.
- MD_Busy  out  1  mult/div unit occupied.
- MD_Done  out  1  one-cycle pulse: HI/LO result valid.

Behaviour:
- Enable outputs are combinational from inputs and registered state.
- Per-cycle priority (first match wins):
  1. freeze = EX_MEM_MemAccess & !MEM_Ready.
     - PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 0.
     - MEM_WB_Bubble = 1; Control_Write = 1; IF_ID_Flush = 0.
     - A pending EX_Branch_Taken is held in the frozen ID/EX and acted on after release.
  2. flush = EX_Branch_Taken.
     - PC_Write = 1, IF_ID_Write = 1, IF_ID_Flush = 1, Control_Write = 0.
     - Overrides md_stall and load_use (the ID instruction is wrong-path).
  3. md_stall = MD_Busy & (ID_MD_Use | ID_MD_Start).
     - PC_Write = 0, IF_ID_Write = 0, Control_Write = 0.
  4. load_use = ID_EX_MemRead & (ID_EX_rt != 0) & (ID_EX_rt == IF_ID_rs | ID_EX_rt == IF_ID_rt).
     - Same outputs as md_stall. Exactly one bubble per load.
  5. Otherwise: all write enables = 1, Control_Write = 1, IF_ID_Flush = 0, MEM_WB_Bubble = 0.
- In cases 2–5: ID_EX_Write = 1, EX_MEM_Write = 1, MEM_WB_Bubble = 0.
- MD accept: ID_MD_Start asserted while case 5 applies in cycle T.
- MD FSM states: MD_IDLE, MD_BUSY, MD_DONE.
  - MD_IDLE → MD_BUSY on accept; counter loads MD_LATENCY-1.
  - MD_BUSY: counter decrements every cycle, including freeze cycles. At counter==0 → MD_DONE.
  - MD_DONE: lasts one cycle, then → MD_IDLE, or → MD_BUSY if another accept occurs in that cycle.
  - MD_Busy = 1 in MD_BUSY, i.e. cycles T+1 .. T+MD_LATENCY.
  - MD_Done = 1 in MD_DONE, i.e. cycle T+MD_LATENCY+1. MD_Busy = 0 in that cycle.
  - An mfhi in ID during MD_DONE proceeds; HI/LO is forwarded by the datapath.
- Reset (asynchronous, any time including mid-divide):
  - MD FSM → MD_IDLE, counter = 0, MD_Busy = 0, MD_Done = 0.
  - With inputs inactive: all write enables = 1, Control_Write = 1, IF_ID_Flush = 0, MEM_WB_Bubble = 0.
  - Any in-flight divide is abandoned.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - Adds output ports perf_stall_cnt (32) and perf_flush_cnt (32).
  - perf_stall_cnt increments in any cycle with PC_Write = 0.
  - perf_flush_cnt increments in any cycle with IF_ID_Flush = 1.
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: lw $5 in EX (ID_EX_MemRead=1, ID_EX_rt=5), IF_ID_rs=5 → one cycle with PC_Write=0, IF_ID_Write=0, Control_Write=0; next cycle all 1. Repeat with ID_EX_rt=0 → no stall.
- Branch beats load-use: EX_Branch_Taken=1 together with a load-use match → IF_ID_Flush=1, Control_Write=0, PC_Write=1.
- Mult/div, MD_LATENCY=4: start accepted at cycle 10 → MD_Busy high cycles 11–14, MD_Done pulse at 15. mfhi presented from cycle 12 → stalled cycles 12–14, issues at 15.
- Memory freeze: EX_MEM_MemAccess=1, MEM_Ready=0 for 3 cycles with EX_Branch_Taken=1 → all enables 0 and MEM_WB_Bubble=1 for 3 cycles, flush asserted on the 4th cycle. MD counter keeps decrementing throughout.
- Reset mid-divide: assert rst at cycle T+2 of a MD_LATENCY=32 divide → MD_Busy=0 and MD_Done=0 immediately (asynchronously); no MD_Done pulse after release.
- STALL_PERF_EN: 3 load-use stalls + 2 flushes → perf_stall_cnt=3, perf_flush_cnt=2. Preload perf_stall_cnt to 32'hFFFFFFFF, apply one more stall → stays at 32'hFFFFFFFF.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline.
// Arbitrates memory wait, taken branch, mult/div busy and load-use hazards.
// Drives the per-stage register enables and owns the mult/div occupancy FSM.
// Optional STALL_PERF_EN macro adds saturating stall/flush event counters.
module pipeline_stall_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  input  logic [4:0] ID_EX_rt,
  input  logic       ID_EX_MemRead,
  input  logic       EX_Branch_Taken,
  input  logic       ID_MD_Start,
  input  logic       ID_MD_Use,
  input  logic       EX_MEM_MemAccess,
  input  logic       MEM_Ready,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       ID_EX_Write,
  output logic       EX_MEM_Write,
  output logic       Control_Write,
  output logic       IF_ID_Flush,
  output logic       MEM_WB_Bubble,
  output logic       MD_Busy,
  output logic       MD_Done
`ifdef STALL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic freeze, flush, md_stall, load_use, accept;

  assign MD_Busy = (state == MD_BUSY);
  assign MD_Done = (state == MD_DONE);

  // Hazard detection; priority is applied in the output mux below.
  always_comb begin
    freeze   = EX_MEM_MemAccess & ~MEM_Ready;
    flush    = EX_Branch_Taken;
    md_stall = MD_Busy & (ID_MD_Use | ID_MD_Start);
    load_use = ID_EX_MemRead & (ID_EX_rt != 5'd0) &
               ((ID_EX_rt == IF_ID_rs) | (ID_EX_rt == IF_ID_rt));
    // A start is only taken when the ID instruction actually issues.
    accept   = ID_MD_Start & ~freeze & ~flush & ~md_stall & ~load_use;
  end

  // Priority mux for the stage enables: freeze > flush > md/load-use stall.
  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    Control_Write = 1'b1;
    IF_ID_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (freeze) begin
      // Whole front end holds; a pending branch stays in the frozen ID/EX.
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (flush) begin
      // ID holds a wrong-path instruction, so any stall it causes is moot.
      IF_ID_Flush   = 1'b1;
      Control_Write = 1'b0;
    end else if (md_stall || load_use) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      Control_Write = 1'b0;
    end
  end

  // Mult/div occupancy next-state; the counter runs through freeze cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MD_IDLE: if (accept) begin
        state_nxt = MD_BUSY;
        cnt_nxt   = CNT_W'(MD_LATENCY - 1);
      end
      MD_BUSY: if (cnt == '0) state_nxt = MD_DONE;
               else           cnt_nxt   = cnt - 1'b1;
      MD_DONE: if (accept) begin
        state_nxt = MD_BUSY;
        cnt_nxt   = CNT_W'(MD_LATENCY - 1);
      end else begin
        state_nxt = MD_IDLE;
      end
      default: begin
        state_nxt = MD_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Mult/div state register; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef STALL_PERF_EN
  // Saturating counters of PC-hold cycles and flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!PC_Write && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (IF_ID_Flush && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MD_LATENCY = 4).
// Output vector order: PC,IFID,IDEX,EXMEM,CW,Flush,Bubble,Busy,Done.
module tb_pipeline_stall_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_rt;
  logic       ID_EX_MemRead, EX_Branch_Taken, ID_MD_Start, ID_MD_Use;
  logic       EX_MEM_MemAccess, MEM_Ready;
  logic       PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic       Control_Write, IF_ID_Flush, MEM_WB_Bubble, MD_Busy, MD_Done;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [8:0] NORM  = 9'h1F0;
  localparam logic [8:0] STALL = 9'h060;
  localparam logic [8:0] FLSH  = 9'h1E8;
  localparam logic [8:0] FRZ   = 9'h014;
  localparam logic [8:0] BUSY  = 9'h002;
  localparam logic [8:0] DONE  = 9'h001;

  pipeline_stall_controller #(.MD_LATENCY(4), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_EX_rt(ID_EX_rt),
    .ID_EX_MemRead(ID_EX_MemRead), .EX_Branch_Taken(EX_Branch_Taken),
    .ID_MD_Start(ID_MD_Start), .ID_MD_Use(ID_MD_Use),
    .EX_MEM_MemAccess(EX_MEM_MemAccess), .MEM_Ready(MEM_Ready),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .Control_Write(Control_Write),
    .IF_ID_Flush(IF_ID_Flush), .MEM_WB_Bubble(MEM_WB_Bubble),
    .MD_Busy(MD_Busy), .MD_Done(MD_Done)
`ifdef STALL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [8:0] outs = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
                     Control_Write, IF_ID_Flush, MEM_WB_Bubble, MD_Busy, MD_Done};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are applied.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Let the combinational outputs settle, then compare the vector.
  task automatic expect_out(input string tag, input logic [8:0] exp);
    #2 chk(tag, {23'd0, outs}, {23'd0, exp});
  endtask

  task automatic idle_in();
    IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; ID_EX_rt = 5'd0;
    ID_EX_MemRead = 1'b0; EX_Branch_Taken = 1'b0;
    ID_MD_Start = 1'b0; ID_MD_Use = 1'b0;
    EX_MEM_MemAccess = 1'b0; MEM_Ready = 1'b1;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    #3 chk("reset_out", {23'd0, outs}, {23'd0, NORM});
    #10 rst = 1'b0;
    tick();

    // Load-use on rs, then the bubble cycle, then rt=$0, then match on rt.
    ID_EX_MemRead = 1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
    expect_out("lu_rs_stall", STALL);
    tick(); ID_EX_MemRead = 0;
    expect_out("lu_release", NORM);
    tick(); ID_EX_MemRead = 1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0;
    expect_out("lu_r0_nostall", NORM);
    tick(); ID_EX_rt = 5'd9; IF_ID_rs = 5'd3; IF_ID_rt = 5'd9;
    expect_out("lu_rt_stall", STALL);
    tick(); IF_ID_rt = 5'd4;
    expect_out("lu_nomatch", NORM);

    // Taken branch wins over a load-use match.
    tick(); ID_EX_rt = 5'd5; IF_ID_rs = 5'd5; EX_Branch_Taken = 1;
    expect_out("br_over_lu", FLSH);

    // Mult/div accept, busy 4 cycles, mfhi stalled until the done cycle.
    tick(); idle_in(); ID_MD_Start = 1;
    expect_out("md_accept", NORM);
    tick(); ID_MD_Start = 0;
    expect_out("md_busy1", NORM | BUSY);
    tick(); ID_MD_Use = 1;
    expect_out("md_use_stall2", STALL | BUSY);
    tick(); expect_out("md_use_stall3", STALL | BUSY);
    tick(); expect_out("md_use_stall4", STALL | BUSY);
    tick(); expect_out("md_done_issue", NORM | DONE);
    tick(); ID_MD_Use = 0;
    expect_out("md_idle", NORM);

    // Freeze 3 cycles with branch pending; MD counter keeps running.
    tick(); ID_MD_Start = 1;
    expect_out("md2_accept", NORM);
    tick(); ID_MD_Start = 0; EX_MEM_MemAccess = 1; MEM_Ready = 0; EX_Branch_Taken = 1;
    expect_out("frz1", FRZ | BUSY);
    tick(); expect_out("frz2", FRZ | BUSY);
    tick(); expect_out("frz3", FRZ | BUSY);
    tick(); MEM_Ready = 1;
    expect_out("frz_release_flush", FLSH | BUSY);
    tick(); idle_in();
    expect_out("frz_md_done", NORM | DONE);

    // Busy blocks a new start; a start during DONE is accepted back-to-back.
    tick(); ID_MD_Start = 1;
    expect_out("md3_accept", NORM);
    tick(); expect_out("md3_start_stall", STALL | BUSY);
    tick(); ID_MD_Start = 0;
    tick(); tick();
    expect_out("md3_busy4", NORM | BUSY);
    tick(); ID_MD_Start = 1;
    expect_out("md3_done_accept", NORM | DONE);
    tick(); ID_MD_Start = 0;
    expect_out("md4_busy1", NORM | BUSY);
    tick(); expect_out("md4_busy2", NORM | BUSY);

    // Asynchronous reset mid-divide; no done pulse may follow.
    #2 rst = 1'b1;
    #1 chk("rst_async", {23'd0, outs}, {23'd0, NORM});
    #4 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); expect_out($sformatf("post_rst_%0d", i), NORM);
    end

`ifdef STALL_PERF_EN
    tick(); rst = 1'b1; #2 rst = 1'b0;
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    chk("perf_flush_rst", perf_flush_cnt, 32'd0);
    tick(); ID_EX_MemRead = 1; ID_EX_rt = 5'd7; IF_ID_rs = 5'd7;
    tick(); tick();
    tick(); idle_in(); EX_Branch_Taken = 1;
    tick();
    tick(); idle_in();
    #2 chk("perf_stall_3", perf_stall_cnt, 32'd3);
    chk("perf_flush_2", perf_flush_cnt, 32'd2);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
